// File: rtl/f_sweep_ctrl.sv
// Truth-table sweep controller: drives {a,b,c} through 0..7 with a settle cycle, captures s per vector.
// Optional golden compare (g = a & ~(b & c)) enabled by defining F_SWEEP_CHECK_EN.
module f_sweep_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       s,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       mismatch,
  output logic [3:0] err_count
);

  localparam int unsigned IDX_W = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [7:0]       table_d;
  logic             busy_d;
  logic             capture_c;

  // Next-state: hold freezes DRIVE/SAMPLE by leaving every default untouched
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    table_d   = truth_table;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          table_d = 8'h00;
        end
      end
      DRIVE: begin
        if (!hold) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (!hold) begin
          capture_c    = 1'b1;
          table_d[idx] = s;
          if (idx == IDX_W'(7)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx + IDX_W'(1);
            state_d = DRIVE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == DRIVE) || (state_d == SAMPLE);

  // State and registered outputs, all decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      truth_table <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      {a, b, c}   <= 3'b000;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      truth_table <= table_d;
      busy        <= busy_d;
      done        <= (state_d == DONE);
      {a, b, c}   <= busy_d ? idx_d : 3'b000;
    end
  end

`ifdef F_SWEEP_CHECK_EN
  logic       golden_c;
  logic       mismatch_q;
  logic [3:0] err_q;

  assign golden_c = a & ~(b & c);

  // Sticky mismatch flag and saturating error counter, cleared on sweep start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_q      <= 4'h0;
    end else if ((state == IDLE) && start) begin
      mismatch_q <= 1'b0;
      err_q      <= 4'h0;
    end else if (capture_c && (s != golden_c)) begin
      mismatch_q <= 1'b1;
      if (err_q != 4'hF) err_q <= err_q + 4'h1;
    end
  end

  assign mismatch  = mismatch_q;
  assign err_count = err_q;
`else
  assign mismatch  = 1'b0;
  assign err_count = 4'h0;
`endif

endmodule

// File: tb/tb_f_sweep_ctrl.sv
// Scoreboard bench for f_sweep_ctrl: random datapath functions, holds and stray start pulses.
module tb_f_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, hold, s;
  logic       a, b, c, busy, done, mismatch;
  logic [7:0] truth_table;
  logic [3:0] err_count;
  logic [7:0] fn;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] tbl;
    logic       mis;
    logic [3:0] err;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  f_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .s(s),
    .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .truth_table(truth_table), .mismatch(mismatch), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: an arbitrary 3-input function held as a lookup table
  always_comb s = fn[{a, b, c}];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the captured table is f itself; errors are vectors where f differs from a&~(b&c)
  function automatic exp_t model(input logic [7:0] f, input int dc);
    exp_t e;
    int   cnt;
    logic [2:0] v;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if (f[i] != (v[2] & ~(v[1] & v[0]))) cnt++;
    end
    e.tbl = f;
`ifdef F_SWEEP_CHECK_EN
    e.mis = (cnt != 0);
    e.err = (cnt > 15) ? 4'hF : 4'(cnt);
`else
    e.mis = 1'b0;
    e.err = 4'h0;
`endif
    e.done_cyc = dc;
    return e;
  endfunction

  // Monitor: pops on every done pulse, checks exclusivity every cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("table", 32'(truth_table), 32'(e.tbl));
          chk("mismatch", 32'(mismatch), 32'(e.mis));
          chk("err_count", 32'(err_count), 32'(e.err));
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        end
      end
    end
  end

  // One sweep; hold_t/pulse_t are active-cycle offsets (even=DRIVE, odd=SAMPLE), -1 = none
  task automatic run_sweep(input logic [7:0] f, input int hold_t, input int hold_len,
                           input int pulse_t, input bit start_in_done);
    int ka, hl;
    fn = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    ka = cyc;
    chk("accept_busy", 32'(busy), 32'd1);
    hl = (hold_t >= 0) ? hold_len : 0;
    sb.push_back(model(f, ka + 16 + hl));
    for (int t = 0; t < 16; t++) begin
      if (t == hold_t) begin
        hold = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          tick();
          chk("hold_abc", 32'({a, b, c}), 32'(t / 2));
          chk("hold_busy", 32'(busy), 32'd1);
        end
        hold = 1'b0;
      end
      if (t == pulse_t) start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_after_done", 32'(busy), 32'd0);
    tick();
    chk("idle_abc", 32'({a, b, c}), 32'd0);
    chk("idle_table_kept", 32'(truth_table), 32'(f));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; fn = 8'h70;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_abc", 32'({a, b, c}), 32'd0);
    chk("rst_table", 32'(truth_table), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    rst = 1'b0;

    // Directed: correct datapath, stuck-at-1, hold in SAMPLE of idx 3, start during sweep and DONE
    run_sweep(8'h70, -1, 0, -1, 1'b0);
    run_sweep(8'hFF, -1, 0, -1, 1'b0);
    run_sweep(8'h70, 7, 5, -1, 1'b0);
    run_sweep(8'h70, -1, 0, 4, 1'b1);
    run_sweep(8'h70, 2, 3, 9, 1'b0);

    // Reset during DRIVE of idx 5 aborts with no done pulse
    begin
      fn = 8'h70;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      chk("pre_rst_abc", 32'({a, b, c}), 32'd5);
      rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_table", 32'(truth_table), 32'd0);
      chk("async_rst_abc", 32'({a, b, c}), 32'd0);
      tick();
      rst = 1'b0;
      repeat (20) tick();
      chk("post_rst_idle", 32'(busy), 32'd0);
      run_sweep(8'h70, -1, 0, -1, 1'b0);
    end

    // start held high: second sweep begins at the first IDLE edge, done pulses 18 apart
    begin
      int ka;
      fn = 8'h70;
      start = 1'b1;
      tick();
      ka = cyc;
      sb.push_back(model(8'h70, ka + 16));
      repeat (18) tick();
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'd1);
      sb.push_back(model(8'h70, ka + 34));
      repeat (19) tick();
      chk("restart_drained", 32'(sb.size()), 32'd0);
      sb.delete();
    end

    // Randomized sweeps
    for (int n = 0; n < 40; n++) begin
      logic [7:0] f;
      int ht, hlen, pt;
      f    = 8'($urandom);
      ht   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15));
      hlen = int'($urandom_range(1, 6));
      pt   = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 15));
      run_sweep(f, ht, hlen, pt, 1'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
